uart_tx_periph: RTL and testbench
=================================

Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter on the PicoRV32 native memory bus, a peer of the GPIO peripheral.
- The top level decodes the region and drives mem_valid. This block answers with mem_ready and q; q is OR-ed onto the shared read bus.
- Firmware writes bytes into a TX FIFO. A bit-timing FSM serialises them as 8N1 frames on the tx pin.
- Provides status, a baud divider, and an optional FIFO-empty interrupt.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of two, minimum 2.
- DEFAULT_DIV, 434, reset value of the baud divider in clocks per bit (50 MHz / 115200).

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- mem_valid  input  1  access request, already region-decoded by the top
- mem_ready  output  1  single-cycle access acknowledge
- addr  input  32  byte address; only addr[3:2] is decoded
- data  input  32  write data
- wstrb  input  4  byte strobes; any non-zero value means write, zero means read
- q  output  32  read data; 0 whenever mem_ready is low
- tx  output  1  serial output; idle high
- irq  output  1  level interrupt

Behaviour:
- One clock; reset is asynchronous and active-low. On reset: mem_ready=0, q=0, tx=1, irq=0, FIFO empty, FSM IDLE, DIV=DEFAULT_DIV, CTRL=0, overflow=0.
- Bus handshake:
  - mem_ready is registered: it goes high the cycle after mem_valid is first seen, for exactly one cycle.
  - mem_ready is never high two consecutive cycles, even if mem_valid stays high.
  - Register side effects and q are both taken on the mem_ready cycle.
- Register map (offset = addr[3:2]*4):
  - 0x0 TXDATA.
    - Write pushes data[7:0] when the FIFO is not full.
    - If full, the byte is dropped and overflow is set.
    - Read returns 0.
  - 0x4 STATUS (RO except bit3):
    - bit0 busy: FSM not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overflow: sticky; writing 1 to bit3 clears it.
    - bits[15:8] FIFO level.
  - 0x8 DIV: [15:0] clocks per bit, read/write. A written value of 0 is stored as 0 and treated as 1.
  - 0xC CTRL: bit0 enable, bit1 irq_en, read/write.
- Full is evaluated before any same-cycle pop. A push to a full FIFO is dropped even if a pop occurs that cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO leave the level unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If enable=1 and FIFO is non-empty, pop the head into the shift register and go to START on the next cycle.
  - START: tx=0 for one bit period, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Shift at each bit end; after 8 bits go to STOP.
  - STOP: tx=1 for one bit period, then IDLE.
  - IDLE re-checks the FIFO in the same cycle it is entered. Back-to-back frames therefore have exactly one idle-high clock between the stop bit and the next start bit.
- Bit period: a counter loads max(DIV,1)-1 and counts down to 0; the bit ends on 0. A DIV write mid-frame takes effect at the next bit boundary.
- Clearing enable mid-frame lets the current frame complete; no further pops occur.
- A reset mid-frame forces tx=1 immediately (asynchronously) and discards FIFO contents.
- irq = irq_en & empty & ~busy, registered (one-cycle lag).
- Frame length is 10 bit periods.

Test Plan:
- Reset with tx and bus idle -> tx=1, mem_ready=0, q=0, DIV readback 434, STATUS=0x0004.
- DIV=4, CTRL=1, write TXDATA 0xA5 -> tx low 4 clk; then bits 1,0,1,0,0,1,0,1 (4 clk each); stop high 4 clk. busy falls 40 clk after the start bit begins.
- DIV=2, enable=0, write 17 bytes -> STATUS level=16, full=1, overflow=1. Write 0x8 to STATUS -> overflow=0. Set enable -> 16 frames emitted with one idle clock between them.
- Hold mem_valid high for 5 cycles on a STATUS read -> mem_ready pulses exactly once, one cycle after valid rises; q=0 on all other cycles.
- CTRL=3, one byte, DIV=3 -> irq=0 during the frame; irq=1 one cycle after busy falls with FIFO empty. Clearing irq_en drops irq one cycle later.
- Assert resetn=0 in the middle of the DATA state -> tx=1 asynchronously. After release: STATUS empty=1 and busy=0, no frame resumes, DIV returns to 434.

Source files
------------

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_periph
// Summary  : Memory-mapped 8N1 UART transmitter with TX FIFO, baud divider,
//            sticky overflow flag and FIFO-empty level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  wstrb,
    output logic [31:0] q,
    output logic        tx,
    output logic        irq
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic                r_ready;
    logic                r_acked;
    logic [15:0]         r_div;
    logic                r_ctrl_en;
    logic                r_ctrl_irq_en;
    logic                r_ovf;
    logic                r_irq;
    logic                r_tx;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_count;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_next;
    logic                w_tx_next;
    logic                w_pop;

    logic                w_wr;
    logic [1:0]          w_sel;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_full;
    logic                w_empty;
    logic                w_busy;
    logic [15:0]         w_period;
    logic                w_bit_end;
    logic [7:0]          w_level;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;
    logic                w_unused_ok;

    assign w_unused_ok = ^{addr[31:4], addr[1:0], data[31:16]};

    // ------------------------------------------------------------------
    // Bus handshake: one acknowledge per request, even if valid is held
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_acked <= 1'b0;
        end else begin
            r_ready <= mem_valid & ~r_ready & ~r_acked;
            r_acked <= mem_valid & (r_acked | r_ready);
        end
    end

    assign mem_ready = r_ready;
    assign w_wr      = r_ready & (|wstrb);
    assign w_sel     = addr[3:2];

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != S_IDLE);
    assign w_push    = w_wr & (w_sel == 2'd0) & ~w_full;
    assign w_ovf_set = w_wr & (w_sel == 2'd0) & w_full;

    // ------------------------------------------------------------------
    // Control/status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div         <= DEFAULT_DIV;
            r_ctrl_en     <= 1'b0;
            r_ctrl_irq_en <= 1'b0;
            r_ovf         <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (w_wr && (w_sel == 2'd2)) begin
                r_div <= data[15:0];
            end
            if (w_wr && (w_sel == 2'd3)) begin
                r_ctrl_en     <= data[0];
                r_ctrl_irq_en <= data[1];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_sel == 2'd1) && data[3]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= r_ctrl_irq_en & w_empty & ~w_busy;
        end
    end

    assign irq = r_irq;

    // ------------------------------------------------------------------
    // TX FIFO; contents need no reset since pointers define validity
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit-timing FSM
    // ------------------------------------------------------------------
    // A divider of 0 behaves like 1 clock per bit.
    assign w_period  = (r_div == 16'd0) ? 16'd0 : (r_div - 16'd1);
    assign w_bit_end = (r_cnt == 16'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl_en && !w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_cnt_next   = w_period;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_next   = w_period;
                    w_idx_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next   = w_period;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_idx_next   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // tx is registered from next-state so the pin never glitches
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
        end
    end

    assign tx = r_tx;

    // ------------------------------------------------------------------
    // Read mux; q is zero outside the acknowledge cycle for bus OR-ing
    // ------------------------------------------------------------------
    assign w_level  = 8'(r_count);
    assign w_status = {16'h0000, w_level, 4'h0, r_ovf, w_empty, w_full, w_busy};

    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_sel)
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {16'h0000, r_div};
            2'd3:    w_rdata = {30'h0, r_ctrl_irq_en, r_ctrl_en};
            default: w_rdata = 32'h0000_0000;
        endcase
    end

    assign q = r_ready ? w_rdata : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_periph
// Summary  : Self-checking bench for uart_tx_periph; transmitted bytes are
//            queued on write and compared against a serial-line monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

    localparam int c_DEPTH = 16;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wstrb;
    logic [31:0] q;
    logic        tx;
    logic        irq;

    int          n_checks;
    int          n_pass;
    int          cyc;
    int          tb_div;
    logic        mon_en;
    logic [7:0]  sb[$];
    int          start_times[$];

    uart_tx_periph #(
        .FIFO_DEPTH  (c_DEPTH),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .addr      (addr),
        .data      (data),
        .wstrb     (wstrb),
        .q         (q),
        .tx        (tx),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        mem_valid = 1'b1;
        addr      = a;
        data      = d;
        wstrb     = s;
        rd        = '0;
        n         = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 8);
        if (!mem_ready) check("bus_ready_timeout", mem_ready, 1);
        else rd = q;
        mem_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, d, 4'hF, dummy);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
        bus_xfer(a, 32'h0, 4'h0, rd);
    endtask

    // Scoreboard holds at most one FIFO's worth while the transmitter is off
    task automatic write_tx(input logic [7:0] b);
        bus_write(32'h0, {24'h0, b});
        if (sb.size() < c_DEPTH) sb.push_back(b);
    endtask

    // Serial monitor: decodes 8N1 frames at bit centres using tb_div
    initial begin : monitor
        int         d;
        int         pos;
        int         t;
        logic [7:0] b;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (mon_en && resetn && tx === 1'b0) begin
                d   = tb_div;
                pos = 0;
                start_times.push_back(cyc);
                for (int i = 0; i < 9; i++) begin
                    t = d * (1 + i) + d / 2;
                    repeat (t - pos) @(negedge clk);
                    pos = t;
                    if (i < 8) b[i] = tx;
                    else check("rx_stop_bit", tx, 1);
                end
                if (sb.size() == 0) begin
                    check("rx_unexpected_byte", b, 8'hxx);
                end else begin
                    exp_b = sb.pop_front();
                    check("rx_byte", b, exp_b);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] rd;
        logic [63:0] obs_w;
        logic [63:0] exp_w;
        logic [7:0]  a5;
        logic [4:0]  rdy_pat;
        logic [31:0] q_other;
        logic [31:0] q_rdy;
        int          n;
        int          lows;
        int          irq_bad;

        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        tb_div    = 434;
        mon_en    = 1'b1;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        addr      = '0;
        data      = '0;
        wstrb     = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_q", q, 0);
        check("rst_irq", irq, 0);
        bus_read(32'h8, rd);
        check("rst_div", rd, 434);
        bus_read(32'h4, rd);
        check("rst_status", rd, 32'h4);

        // ---------------- single frame 0xA5, DIV=4 ----------------
        tb_div = 4;
        bus_write(32'h8, 4);
        bus_write(32'hC, 1);
        write_tx(8'hA5);
        a5    = 8'hA5;
        exp_w = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_w[i] = 1'b0;
            else if (i < 36) exp_w[i] = a5[(i - 4) / 4];
            else             exp_w[i] = 1'b1;
        end
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("a5_start_seen", tx, 0);
        obs_w = '0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            obs_w[i] = tx;
            if (i == 39) check("a5_busy_end_of_frame", dut.w_busy, 1);
        end
        check("a5_waveform", obs_w, exp_w);
        @(negedge clk);
        check("a5_busy_fall_40", dut.w_busy, 0);
        bus_read(32'h4, rd);
        check("a5_status_after", rd, 32'h4);

        // ---------------- overflow and back-to-back, DIV=2 ----------------
        tb_div = 2;
        bus_write(32'hC, 0);
        bus_write(32'h8, 2);
        for (int i = 0; i < 17; i++) write_tx(8'($urandom_range(0, 255)));
        bus_read(32'h4, rd);
        check("ovf_status_full", rd, 32'h0000_100A);
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, rd);
        check("ovf_status_cleared", rd, 32'h0000_1002);
        start_times.delete();
        bus_write(32'hC, 1);
        n = 0;
        while (sb.size() != 0 && n < 16 * 21 + 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", sb.size(), 0);
        check("b2b_frames", start_times.size(), 16);
        for (int i = 1; i < start_times.size(); i++)
            check("b2b_gap", start_times[i] - start_times[i-1], 21);
        repeat (4) @(negedge clk);
        bus_read(32'h4, rd);
        check("b2b_status_after", rd, 32'h4);

        // ---------------- held mem_valid ----------------
        @(negedge clk);
        mem_valid = 1'b1;
        addr      = 32'h4;
        wstrb     = 4'h0;
        rdy_pat   = '0;
        q_other   = '0;
        q_rdy     = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rdy_pat[i] = mem_ready;
            if (mem_ready) q_rdy = q;
            else q_other = q_other | q;
        end
        mem_valid = 1'b0;
        check("hold_ready_pattern", rdy_pat, 5'b00001);
        check("hold_q_on_ready", q_rdy, 32'h4);
        check("hold_q_otherwise", q_other, 0);

        // ---------------- interrupt ----------------
        tb_div = 3;
        bus_write(32'h8, 3);
        bus_write(32'hC, 0);
        write_tx(8'h3C);
        bus_write(32'hC, 3);
        irq_bad = 0;
        n = 0;
        while (!dut.w_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("irq_frame_started", dut.w_busy, 1);
        n = 0;
        while (dut.w_busy && n < 60) begin
            if (irq) irq_bad++;
            @(negedge clk);
            n++;
        end
        check("irq_low_during_frame", irq_bad, 0);
        check("irq_busy_fell", dut.w_busy, 0);
        check("irq_at_busy_fall", irq, 0);
        @(negedge clk);
        check("irq_one_after_fall", irq, 1);
        bus_write(32'hC, 1);
        @(negedge clk);
        check("irq_clear_same", irq, 1);
        @(negedge clk);
        check("irq_clear_next", irq, 0);

        // ---------------- reset mid-frame ----------------
        mon_en = 1'b0;
        tb_div = 4;
        bus_write(32'h8, 4);
        bus_write(32'hC, 0);
        bus_write(32'h0, 0);
        bus_write(32'h0, 0);
        bus_write(32'hC, 1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check("midrst_tx_low_in_data", tx, 0);
        #1 resetn = 1'b0;
        #1 check("midrst_tx_async", tx, 1);
        check("midrst_ready", mem_ready, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        bus_read(32'h4, rd);
        check("midrst_status", rd, 32'h4);
        bus_read(32'h8, rd);
        check("midrst_div", rd, 434);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("midrst_no_resume", lows, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
